// File: rtl/flow_bus_arbiter_pkg.sv
// Shared flow-bus helpers: handshake macros and a constant-evaluable clog2.
`ifndef FLOW_BUS_MACROS_SVH
`define FLOW_BUS_MACROS_SVH
`define FLOW_BUS_XFER(valid, ready) ((valid) && (ready))
`define FLOW_BUS_STALL(valid, ready) ((valid) && !(ready))
`endif

package flow_bus_arbiter_pkg;

    // Ceiling log2; clog2(1) is 0, so callers apply their own minimum width.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/flow_bus_arbiter_rr_priority_select.sv
// Round-robin search: first asserted request strictly after last_grant, with wrap.
module rr_priority_select
    import flow_bus_arbiter_pkg::*;
#(
    parameter int PORT_NUM  = 4,
    parameter int SEL_WIDTH = (clog2(PORT_NUM) > 1) ? clog2(PORT_NUM) : 1
) (
    input  logic [PORT_NUM-1:0]  req,
    input  logic [SEL_WIDTH-1:0] last_grant,
    output logic [SEL_WIDTH-1:0] grant,
    output logic                 found
);

    int idx;

    // last_grant itself is visited last, so a lone requester still wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= PORT_NUM; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= PORT_NUM) begin
                idx = idx - PORT_NUM;
            end
            if (!found && req[idx[SEL_WIDTH-1:0]]) begin
                found = 1'b1;
                grant = idx[SEL_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/flow_bus_arbiter.sv
// Burst-locked round-robin arbiter: PORT_NUM flow-bus sources onto one sink,
// BURST_LEN accepted words per grant so downstream word groups stay aligned.
module flow_bus_arbiter
    import flow_bus_arbiter_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int PORT_NUM   = 4,
    parameter  int BURST_LEN  = 2,
    localparam int SEL_WIDTH  = (clog2(PORT_NUM) > 1) ? clog2(PORT_NUM) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [PORT_NUM-1:0]            up_valid,
    output logic [PORT_NUM-1:0]            up_ready,
    input  logic [PORT_NUM*DATA_WIDTH-1:0] up_data,
    input  logic                           down_ready,
    output logic                           down_valid,
    output logic [DATA_WIDTH-1:0]          down_data,
    output logic [SEL_WIDTH-1:0]           down_sel,
    output logic                           down_last
);

    localparam int                    BEAT_WIDTH = clog2(BURST_LEN) + 1;
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT  = BEAT_WIDTH'(BURST_LEN - 1);
    localparam logic [SEL_WIDTH-1:0]  RESET_LAST = SEL_WIDTH'(PORT_NUM - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_e;

    state_e                state_q, state_d;
    logic [SEL_WIDTH-1:0]  grant_q, grant_d;
    logic [SEL_WIDTH-1:0]  last_grant_q, last_grant_d;
    logic [BEAT_WIDTH-1:0] beat_q, beat_d;
    logic [SEL_WIDTH-1:0]  next_grant;
    logic                  next_found;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] up_words [PORT_NUM];

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_unpack
        assign up_words[p] = up_data[p*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_select #(
        .PORT_NUM  (PORT_NUM),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_select (
        .req        (up_valid),
        .last_grant (last_grant_q),
        .grant      (next_grant),
        .found      (next_found)
    );

    // Granted port passes straight through; down_ready only feeds up_ready.
    always_comb begin
        down_valid = 1'b0;
        down_data  = '0;
        down_last  = 1'b0;
        up_ready   = '0;
        if (state_q == ST_GRANT) begin
            down_valid        = up_valid[grant_q];
            down_data         = up_words[grant_q];
            down_last         = (beat_q == LAST_BEAT) && down_valid;
            up_ready[grant_q] = down_ready;
        end
    end

    assign down_sel = grant_q;
    assign xfer     = `FLOW_BUS_XFER(down_valid, down_ready);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && next_found) begin
                    state_d      = ST_GRANT;
                    grant_d      = next_grant;
                    last_grant_d = next_grant;
                    beat_d       = '0;
                end
            end
            ST_GRANT: begin
                // enable is ignored here: a started burst always completes.
                if (xfer) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= RESET_LAST;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
        end
    end

endmodule

// File: tb/tb_flow_bus_arbiter.sv
// Directed bench for flow_bus_arbiter with PORT_NUM=4, BURST_LEN=2, DATA_WIDTH=8.
module tb_flow_bus_arbiter;

    localparam int DW = 8;
    localparam int PN = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable;
    logic [PN-1:0] up_valid;
    logic [PN-1:0] up_ready;
    logic [PN*DW-1:0] up_data;
    logic          down_ready;
    logic          down_valid;
    logic [DW-1:0] down_data;
    logic [SW-1:0] down_sel;
    logic          down_last;

    logic [15:0] obs;
    logic [15:0] exp_v;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flow_bus_arbiter #(
        .DATA_WIDTH (DW),
        .PORT_NUM   (PN),
        .BURST_LEN  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .down_ready (down_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_sel   (down_sel),
        .down_last  (down_last)
    );

    // Observed bundle: {valid, last, sel, up_ready, data}
    assign obs = {down_valid, down_last, down_sel, up_ready, down_data};

    function automatic logic [15:0] pack(input logic v, input logic l, input logic [1:0] s,
                                         input logic [3:0] r, input logic [7:0] d);
        return {v, l, s, r, d};
    endfunction

    function automatic logic [PN*DW-1:0] words(input logic [7:0] base);
        return {base + 8'd3, base + 8'd2, base + 8'd1, base};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        up_valid   = '0;
        enable     = 1'b1;
        down_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        up_data    = words(8'hA0);
        up_valid   = 4'b1111;
        enable     = 1'b1;
        down_ready = 1'b1;
        #2 rst = 1'b0;
        repeat (3) tick();
        exp_v = pack(1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL reset_hold: got %h expected %h", obs, exp_v); end
        rst = 1'b1;
        tick();
        exp_v = pack(1'b1, 1'b0, 2'd0, 4'b0001, 8'hA0);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL reset_first_grant: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_fairness();
        int port;
        do_reset();
        up_data  = words(8'h00);
        up_valid = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            port = b % PN;
            tick();
            exp_v = pack(1'b1, 1'b0, 2'(port), 4'(1 << port), 8'(port));
            checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL fair_word1 burst %0d: got %h expected %h", b, obs, exp_v); end
            tick();
            exp_v = pack(1'b1, 1'b1, 2'(port), 4'(1 << port), 8'(port));
            checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL fair_word2 burst %0d: got %h expected %h", b, obs, exp_v); end
            tick();
            exp_v = pack(1'b0, 1'b0, 2'(port), 4'b0000, 8'h00);
            checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL fair_bubble burst %0d: got %h expected %h", b, obs, exp_v); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        up_data  = words(8'h50);
        up_valid = 4'b0100;
        tick();
        exp_v = pack(1'b1, 1'b0, 2'd2, 4'b0100, 8'h52);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL bp_word1: got %h expected %h", obs, exp_v); end
        tick();
        down_ready = 1'b0;
        #1;
        exp_v = pack(1'b1, 1'b1, 2'd2, 4'b0000, 8'h52);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL bp_stall: got %h expected %h", obs, exp_v); end
        tick();
        down_ready = 1'b1;
        #1;
        exp_v = pack(1'b1, 1'b1, 2'd2, 4'b0100, 8'h52);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL bp_word2: got %h expected %h", obs, exp_v); end
        tick();
        exp_v = pack(1'b0, 1'b0, 2'd2, 4'b0000, 8'h00);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL bp_idle: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_source_stall();
        do_reset();
        up_data  = words(8'h30);
        up_valid = 4'b1010;
        tick();
        exp_v = pack(1'b1, 1'b0, 2'd1, 4'b0010, 8'h31);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL stall_word1: got %h expected %h", obs, exp_v); end
        tick();
        up_valid = 4'b1000;
        #1;
        exp_v = pack(1'b0, 1'b0, 2'd1, 4'b0010, 8'h31);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL stall_drop: got %h expected %h", obs, exp_v); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL stall_hold cycle %0d: got %h expected %h", c, obs, exp_v); end
        end
        tick();
        up_valid = 4'b1010;
        #1;
        exp_v = pack(1'b1, 1'b1, 2'd1, 4'b0010, 8'h31);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL stall_word2: got %h expected %h", obs, exp_v); end
        tick();
        exp_v = pack(1'b0, 1'b0, 2'd1, 4'b0000, 8'h00);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL stall_bubble: got %h expected %h", obs, exp_v); end
        tick();
        exp_v = pack(1'b1, 1'b0, 2'd3, 4'b1000, 8'h33);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL stall_next_p3: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_enable();
        do_reset();
        up_data  = words(8'h60);
        up_valid = 4'b1111;
        tick();
        exp_v = pack(1'b1, 1'b0, 2'd0, 4'b0001, 8'h60);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL en_word1: got %h expected %h", obs, exp_v); end
        tick();
        enable = 1'b0;
        #1;
        exp_v = pack(1'b1, 1'b1, 2'd0, 4'b0001, 8'h60);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL en_word2: got %h expected %h", obs, exp_v); end
        tick();
        exp_v = pack(1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL en_idle: got %h expected %h", obs, exp_v); end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL en_no_grant cycle %0d: got %h expected %h", c, obs, exp_v); end
        end
        enable = 1'b1;
        #1;
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL en_return_latency: got %h expected %h", obs, exp_v); end
        tick();
        exp_v = pack(1'b1, 1'b0, 2'd1, 4'b0010, 8'h61);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL en_grant_p1: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_mid_burst_reset();
        do_reset();
        up_data  = words(8'h70);
        up_valid = 4'b0100;
        tick();
        exp_v = pack(1'b1, 1'b0, 2'd2, 4'b0100, 8'h72);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL mr_word1: got %h expected %h", obs, exp_v); end
        tick();
        exp_v = pack(1'b1, 1'b1, 2'd2, 4'b0100, 8'h72);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL mr_word2_pending: got %h expected %h", obs, exp_v); end
        rst      = 1'b0;
        up_valid = 4'b1111;
        #1;
        exp_v = pack(1'b0, 1'b0, 2'd0, 4'b0000, 8'h00);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL mr_async_clear: got %h expected %h", obs, exp_v); end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        exp_v = pack(1'b1, 1'b0, 2'd0, 4'b0001, 8'h70);
        checks++; if (obs !== exp_v) begin errors++; $display("[TB] FAIL mr_restart_p0: got %h expected %h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_source_stall();
        test_enable();
        test_mid_burst_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/flow_bus_arbiter.md
Name: flow_bus_arbiter

Overview:
- Round-robin arbiter sharing one downstream flow bus (valid/ready/data) between PORT_NUM upstream flow-bus requesters.
- Grants are burst-locked: once a port is granted, it owns the bus for exactly BURST_LEN accepted words. This keeps word groups aligned for a downstream flow_bus_deserializer configured with DATA_NUM = BURST_LEN.
- Sits in front of the deserializer in multi-source capture paths.

Parameters:
- DATA_WIDTH, 8, width of one data word.
- PORT_NUM, 4, number of upstream requesters (2..16).
- BURST_LEN, 2, words transferred per grant (1..256); set equal to the downstream DATA_NUM.
- SEL_WIDTH, clog2(PORT_NUM) (minimum 1), width of down_sel; derived, not overridden.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  permits new grants; never aborts a burst in progress.
- up_valid  in  PORT_NUM  per-port valid.
- up_ready  out  PORT_NUM  per-port ready; one-hot or zero.
- up_data  in  PORT_NUM*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- down_ready  in  1  downstream ready.
- down_valid  out  1  downstream valid.
- down_data  out  DATA_WIDTH  word from the granted port.
- down_sel  out  SEL_WIDTH  index of the granted port.
- down_last  out  1  high with the final word of a burst.

Behaviour:
- Transfer definition: a word transfers on a clock edge where down_valid && down_ready.
- Reset (rst low, asynchronous):
  - State returns to IDLE; beat counter = 0; last_grant = PORT_NUM-1, so port 0 has first priority.
  - Outputs: down_valid = 0, up_ready = 0, down_last = 0, down_sel = 0, down_data = 0.
  - A reset mid-burst discards the partial burst. There is no recovery beat.
- IDLE:
  - All handshake outputs are 0. down_data = 0 and down_sel holds its previous value.
  - If enable = 1 and any up_valid is high, grant the first valid port searching upward from last_grant+1 with wrap-around. Register grant, set last_grant = grant, clear the beat counter, and go to GRANT.
  - Arbitration latency is 1 cycle: the granted word can transfer no earlier than the cycle after the request is seen.
- GRANT (combinational pass-through of the granted port g):
  - down_valid = up_valid[g]; down_data = up_data[g]; up_ready[g] = down_ready; all other up_ready = 0; down_sel = g.
  - down_last = (beat == BURST_LEN-1) && down_valid.
  - On each transfer, beat increments. On the transfer where beat == BURST_LEN-1, go to IDLE.
  - This gives one bubble cycle between bursts; peak throughput is BURST_LEN/(BURST_LEN+1).
- Granted port drops up_valid mid-burst: the grant is held, down_valid = 0, and the arbiter waits indefinitely. Other ports are not served until the burst completes.
- enable falls during GRANT: the burst completes normally; no new grant is issued while enable = 0.
- Non-granted ports: they may hold valid indefinitely; their data must be held stable by the source, per the flow-bus rules.
- Fairness: with all ports continuously valid, grants cycle 0,1,..,PORT_NUM-1,0,...
- BURST_LEN = 1: each grant carries one word and down_last is high on every transfer.
- Beat counter width is clog2(BURST_LEN)+1; no wrap is possible because the counter clears on grant.
- No combinational path from down_ready to down_valid.

Decomposition:
- Shared flow-bus package: clog2 function and flow-bus handshake helper macros. No new typedefs.
- One natural sub-module: rr_priority_select (PORT_NUM requests plus last_grant -> next grant index and a found flag), purely combinational.
- The FSM and beat counter stay in flow_bus_arbiter.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with all up_valid=1 -> down_valid=0, up_ready=0000, down_last=0. First grant after release is port 0.
2. Fairness: PORT_NUM=4, BURST_LEN=2, all ports valid, down_ready=1, data=port index -> down_data sequence 0,0,1,1,2,2,3,3,0,0. down_last on every 2nd word, with one bubble between bursts.
3. Backpressure: port 2 only valid, down_ready toggling 1,0,1 -> the 2 words transfer only on ready cycles. up_ready[2] mirrors down_ready; down_last is asserted with word 2 only.
4. Source stall: granted port 1 drops valid after word 1 for 5 cycles while port 3 is valid -> no port-3 words appear until port 1 sends word 2. The next grant then goes to port 3.
5. Enable: drop enable mid-burst -> the burst completes. No grant occurs for 10 cycles with ports valid; the next grant is issued 1 cycle after enable returns to 1.
6. Mid-burst reset: assert rst after word 1 of a port-2 burst -> outputs clear immediately (asynchronously). After release, the grant restarts at port 0, not port 3.
